jh_mem_1p_arb: RTL and testbench

JH_MEM_1P_ARB -- requirements
Module: jh_mem_1p_arb

---
 rtl/jh_mem_arb_pkg.sv | 15 +
 rtl/jh_mem_req_if.sv | 29 ++
 rtl/jh_rr_arb2.sv | 35 +++
 rtl/jh_mem_1p_arb.sv | 133 +++++++++++++
 tb/tb_jh_mem_1p_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jh_mem_arb_pkg.sv
// Shared types for the single-port SRAM arbiter: read-tracking FSM states
// and the requester id carried from grant to response.
package jh_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } rd_state_t;

  typedef logic req_id_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/jh_mem_req_if.sv
// One requester port of the SRAM arbiter: request channel plus read-response channel.
interface jh_mem_req_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  // Request moves when valid && ready in the same cycle; ready may depend on
  // valid. Read response moves when rvalid && rready; rdata is held until then.
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [DATA_WIDTH-1:0] bit_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rready;

  modport master (
    output valid, we, bit_en, addr, wdata, rready,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, bit_en, addr, wdata, rready,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/jh_rr_arb2.sv
// Two-input round-robin picker; the pointer moves past the winner only
// when advance is asserted and something is granted.
module jh_rr_arb2
  import jh_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  req_id_t prio_q;

  always_comb begin
    gnt = 2'b00;
    if (prio_q == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  // Winner 0 hands priority to 1 and vice versa.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      prio_q <= 1'b0;
    end else if (adv && (gnt != 2'b00)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/jh_mem_1p_arb.sv
// Two-requester arbiter for a single-port SRAM with one-cycle read latency.
// Writes finish at grant; one read at a time is tracked through IDLE/RD/RSP.
module jh_mem_1p_arb
  import jh_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_b,
  jh_mem_req_if.slave           req0,
  jh_mem_req_if.slave           req1,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_bit_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output rd_state_t             state_dbg
);

  rd_state_t             state_q, state_d;
  req_id_t               pend_id_q, pend_id_d;
  req_id_t               owner_q, owner_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic       rvalid0, rvalid1;
  logic       rsp_accept;
  logic       rd_ok;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       gnt_we;
  logic       rd_gnt;
  req_id_t    gnt_id;

  assign rvalid0    = rst_b && (state_q == RSP) && (owner_q == 1'b0);
  assign rvalid1    = rst_b && (state_q == RSP) && (owner_q == 1'b1);
  assign rsp_accept = (rvalid0 && req0.rready) || (rvalid1 && req1.rready);

  // A read may start only when no read is outstanding, or when the held
  // response leaves in this very cycle.
  assign rd_ok   = (state_q == IDLE) || rsp_accept;
  assign elig[0] = rst_b && req0.valid && (req0.we || rd_ok);
  assign elig[1] = rst_b && req1.valid && (req1.we || rd_ok);

  jh_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_b (rst_b),
    .req   (elig),
    .adv   (|elig),
    .gnt   (gnt)
  );

  assign gnt_id = gnt[1];
  assign gnt_we = gnt[1] ? req1.we : req0.we;
  assign rd_gnt = (gnt != 2'b00) && !gnt_we;

  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];

  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_bit_en = '0;
    mem_wdata  = '0;
    if (gnt[0]) begin
      mem_re     = !req0.we;
      mem_we     = req0.we;
      mem_addr   = req0.addr;
      mem_bit_en = req0.bit_en;
      mem_wdata  = req0.wdata;
    end else if (gnt[1]) begin
      mem_re     = !req1.we;
      mem_we     = req1.we;
      mem_addr   = req1.addr;
      mem_bit_en = req1.bit_en;
      mem_wdata  = req1.wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_id_d = pend_id_q;
    owner_d   = owner_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_gnt) begin
          state_d   = RD;
          pend_id_d = gnt_id;
        end
      end
      RD: begin
        state_d = RSP;
        rdata_d = mem_rdata;
        owner_d = pend_id_q;
      end
      RSP: begin
        if (rsp_accept) begin
          if (rd_gnt) begin
            state_d   = RD;
            pend_id_d = gnt_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      pend_id_q <= 1'b0;
      owner_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_id_q <= pend_id_d;
      owner_q   <= owner_d;
      rdata_q   <= rdata_d;
    end
  end

  assign req0.rvalid = rvalid0;
  assign req1.rvalid = rvalid1;
  assign req0.rdata  = rvalid0 ? rdata_q : '0;
  assign req1.rdata  = rvalid1 ? rdata_q : '0;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_jh_mem_1p_arb.sv
// Bench for jh_mem_1p_arb: SRAM model, cycle-level reference of the
// arbitration rules, and a response scoreboard fed at each read grant.
module tb_jh_mem_1p_arb;
  import jh_mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  jh_mem_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req0 ();
  jh_mem_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req1 ();

  logic          mem_re, mem_we;
  logic [DW-1:0] mem_bit_en, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  rd_state_t     state_dbg;

  jh_mem_1p_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req0       (req0),
    .req1       (req1),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_bit_en (mem_bit_en),
    .mem_wdata  (mem_wdata),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  // SRAM driven by the DUT's memory port; read data one cycle after mem_re.
  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= sram[mem_addr];
    if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_bit_en) | (mem_wdata & mem_bit_en);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries: {requester id, expected read data}.
  logic [DW:0] exp_q[$];

  // Reference state in plain terms: is a read outstanding, who owns it,
  // in which cycle was it granted, and which requester is preferred next.
  int cyc      = 0;
  bit busy     = 1'b0;
  int rd_owner = 0;
  int rd_cyc   = 0;
  int prio     = 0;

  always begin : ref_model
    logic [1:0]    vld, wen, rrd, elig, exp_rv;
    bit            rsp_shown, accept, rd_ok;
    int            win;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_be, w_wd;
    @(negedge clk);
    #1;
    vld    = {req1.valid, req0.valid};
    wen    = {req1.we, req0.we};
    rrd    = {req1.rready, req0.rready};
    win    = -1;
    exp_rv = 2'b00;
    w_addr = '0;
    w_be   = '0;
    w_wd   = '0;
    if (!rst_b) begin
      chk("rst_ready0", req0.ready, 0);
      chk("rst_ready1", req1.ready, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rvalid0", req0.rvalid, 0);
      chk("rst_rvalid1", req1.rvalid, 0);
      busy = 1'b0;
      prio = 0;
      exp_q.delete();
    end else begin
      rsp_shown = busy && (cyc >= rd_cyc + 2);
      if (rsp_shown) exp_rv[rd_owner] = 1'b1;
      accept = rsp_shown && rrd[rd_owner];
      rd_ok  = !busy || accept;
      for (int n = 0; n < 2; n++) elig[n] = vld[n] && (wen[n] || rd_ok);
      if (elig[prio])          win = prio;
      else if (elig[1 - prio]) win = 1 - prio;
      if (win == 0) begin
        w_addr = req0.addr; w_be = req0.bit_en; w_wd = req0.wdata;
      end else if (win == 1) begin
        w_addr = req1.addr; w_be = req1.bit_en; w_wd = req1.wdata;
      end
      chk("ready0", req0.ready, win == 0);
      chk("ready1", req1.ready, win == 1);
      chk("mem_re", mem_re, (win >= 0) ? !wen[win] : 1'b0);
      chk("mem_we", mem_we, (win >= 0) ? wen[win] : 1'b0);
      chk("mem_addr", mem_addr, w_addr);
      chk("mem_bit_en", mem_bit_en, w_be);
      chk("mem_wdata", mem_wdata, w_wd);
      chk("rvalid0", req0.rvalid, exp_rv[0]);
      chk("rvalid1", req1.rvalid, exp_rv[1]);
      if (!exp_rv[0]) chk("rdata0_zero", req0.rdata, 0);
      if (!exp_rv[1]) chk("rdata1_zero", req1.rdata, 0);
      chk("fsm_idle", state_dbg == IDLE, !busy);
      if (accept) busy = 1'b0;
      if (win >= 0) begin
        prio = 1 - win;
        if (wen[win]) begin
          ref_mem[w_addr] = (ref_mem[w_addr] & ~w_be) | (w_wd & w_be);
        end else begin
          exp_q.push_back({(win == 1), ref_mem[w_addr]});
          busy     = 1'b1;
          rd_owner = win;
          rd_cyc   = cyc;
        end
      end
    end
    cyc++;
  end

  // Response monitor: compares whatever the DUT presents against the queue
  // head every cycle, and retires the entry when the requester accepts it.
  always begin : rsp_monitor
    logic          id;
    logic [DW-1:0] rd;
    @(negedge clk);
    #2;
    if (req0.rvalid || req1.rvalid) begin
      id = req1.rvalid;
      rd = id ? req1.rdata : req0.rdata;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d data=%0h required none at %0t", id, rd, $time);
      end else begin
        chk("rsp_id", id, exp_q[0][DW]);
        chk("rsp_data", rd, exp_q[0][DW-1:0]);
        if (id ? req1.rready : req0.rready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    req0.valid = 1'b0; req0.we = 1'b0; req0.bit_en = '0; req0.addr = '0; req0.wdata = '0; req0.rready = 1'b0;
    req1.valid = 1'b0; req1.we = 1'b0; req1.bit_en = '0; req1.addr = '0; req1.wdata = '0; req1.rready = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_req(input int n, input logic we, input logic [DW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    if (n == 0) begin
      req0.valid = 1'b1; req0.we = we; req0.bit_en = be; req0.addr = addr; req0.wdata = wd;
    end else begin
      req1.valid = 1'b1; req1.we = we; req1.bit_en = be; req1.addr = addr; req1.wdata = wd;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    rst_b = 1'b0;
    clear_inputs();
    repeat (2) nxt();
    nxt(); rst_b = 1'b1;

    // Single read after a full write.
    nxt(); set_req(0, 1'b1, '1, 16'h0010, 32'h1234_5678);
    nxt(); set_req(0, 1'b0, '0, 16'h0010, '0); req0.rready = 1'b1;
    repeat (3) begin nxt(); req0.rready = 1'b1; end

    // Partial write over all-ones, then read back.
    nxt(); set_req(0, 1'b1, '1, 16'h0020, 32'hFFFF_FFFF);
    nxt(); set_req(0, 1'b1, 32'h0000_FFFF, 16'h0020, 32'hAAAA_BBBB);
    nxt(); set_req(0, 1'b0, '0, 16'h0020, '0); req0.rready = 1'b1;
    repeat (3) begin nxt(); req0.rready = 1'b1; end

    // Both requesters write every cycle right after reset.
    nxt(); rst_b = 1'b0;
    nxt(); rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, '1, 16'h0100 + 16'(i), $urandom);
      set_req(1, 1'b1, '1, 16'h0200 + 16'(i), $urandom);
      nxt();
    end

    // Held response with req0 writing and req1 retrying reads.
    set_req(1, 1'b0, '0, 16'h0010, '0);
    for (int i = 0; i < 7; i++) begin
      nxt();
      set_req(0, 1'b1, '1, 16'h0040 + 16'(i), $urandom);
      set_req(1, 1'b0, '0, 16'h0011, '0);
    end
    nxt(); req1.rready = 1'b1;
    repeat (2) nxt();

    // Back-to-back reads: req1 read lands in the cycle req0 accepts.
    nxt(); set_req(0, 1'b0, '0, 16'h0010, '0);
    nxt();
    nxt(); req0.rready = 1'b1; set_req(1, 1'b0, '0, 16'h0020, '0);
    repeat (3) begin nxt(); req1.rready = 1'b1; end

    // Reset while the read is in RD; req0 must win first afterwards.
    nxt(); set_req(1, 1'b0, '0, 16'h0010, '0); req1.rready = 1'b1;
    nxt(); rst_b = 1'b0; set_req(0, 1'b1, '1, 16'h0300, 32'h1);
    set_req(1, 1'b1, '1, 16'h0301, 32'h2);
    nxt(); rst_b = 1'b1; set_req(0, 1'b1, '1, 16'h0302, 32'h3);
    set_req(1, 1'b1, '1, 16'h0303, 32'h4);
    repeat (3) begin nxt(); req0.rready = 1'b1; req1.rready = 1'b1; end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      nxt();
      rst_b = ($urandom_range(0, 99) != 0);
      for (int n = 0; n < 2; n++) begin
        logic [DW-1:0] be;
        case ($urandom_range(0, 2))
          0:       be = '1;
          1:       be = 32'h0000_FFFF;
          default: be = $urandom;
        endcase
        if ($urandom_range(0, 3) != 0)
          set_req(n, logic'($urandom_range(0, 1)), be, 16'($urandom_range(0, 15)), $urandom);
      end
      req0.rready = ($urandom_range(0, 3) != 0);
      req1.rready = ($urandom_range(0, 3) != 0);
    end

    nxt(); rst_b = 1'b1;
    repeat (5) begin nxt(); req0.rready = 1'b1; req1.rready = 1'b1; end
    nxt();
    #3;
    chk("drain_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
